// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
package dmem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] PARK_ADDR_DEFAULT = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Big-endian lane handling: the addressed byte always sits in bits [31:24] of the memory word.
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] load_word,
    input  logic [31:0] base_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic sign_fill;

    always_comb begin
        sign_fill = 1'b0;
        load_data = load_word;
        case (size)
            SZ_BYTE: begin
                sign_fill = ~is_unsigned & load_word[31];
                load_data = {{24{sign_fill}}, load_word[31:24]};
            end
            SZ_HALF: begin
                sign_fill = ~is_unsigned & load_word[31];
                load_data = {{16{sign_fill}}, load_word[31:16]};
            end
            default: load_data = load_word;
        endcase
    end

    // Narrow stores replace the leading lanes and keep the rest of the word read back earlier.
    always_comb begin
        merged_word = store_data;
        case (size)
            SZ_BYTE: merged_word = {store_data[7:0], base_word[23:0]};
            SZ_HALF: merged_word = {store_data[15:0], base_word[15:0]};
            default: merged_word = store_data;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the byte-addressed big-endian 32-bit data memory.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] PARK_ADDR = PARK_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        write_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;
    logic [31:0] rword_q;
    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        req_err;

    assign req_err = (req_size == 2'b11)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                   | (req_addr > 32'(DEPTH - 4));

    lsu_lane_align u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .load_word   (mem_rdata),
        .base_word   (rword_q),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= SZ_BYTE;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rword_q    <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        size_q     <= req_size;
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata;
                        if (req_err) begin
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else if (req_write && req_size == SZ_WORD) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                // The read word is kept both as the load result and as the base for a narrow store merge.
                READ: begin
                    rword_q <= mem_rdata;
                    if (write_q) begin
                        state <= WRITE;
                    end else begin
                        resp_rdata <= load_data;
                        resp_error <= 1'b0;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_error <= 1'b0;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the state so a reset pulls mem_write low without waiting for a clock.
    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign mem_read    = (state != WRITE);
    assign mem_write   = (state == WRITE);
    assign mem_address = (state == READ || state == WRITE) ? addr_q : PARK_ADDR;
    assign mem_wdata   = (state == WRITE) ? merged_word : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized and directed bench for dmem_lsu with a byte-array memory and a byte-level reference model.
module tb_dmem_lsu;

    localparam int          DEPTH = 256;
    localparam logic [31:0] PARK  = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    logic [7:0]  mem [DEPTH];
    logic [7:0]  ref_mem [DEPTH];

    int n_checks;
    int n_fail;

    dmem_lsu #(.DEPTH(DEPTH), .PARK_ADDR(PARK)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory read data only refreshes when the address moves while reading.
    always @(mem_address) begin
        if (mem_read && mem_address <= 32'(DEPTH - 4))
            mem_rdata = {mem[mem_address], mem[mem_address + 1], mem[mem_address + 2], mem[mem_address + 3]};
    end

    always @(negedge clk) begin
        if (mem_write && mem_address <= 32'(DEPTH - 4)) begin
            mem[mem_address]     <= mem_wdata[31:24];
            mem[mem_address + 1] <= mem_wdata[23:16];
            mem[mem_address + 2] <= mem_wdata[15:8];
            mem[mem_address + 3] <= mem_wdata[7:0];
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
    endfunction

    // Reference model: decides the outcome from the access rules and updates the reference bytes.
    task automatic model_req(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] e_rd, output logic e_err, output int e_lat,
                             output int e_nr, output int e_nw);
        logic [31:0] w;
        e_err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
                || (a > 32'(DEPTH - 4));
        e_rd = 0; e_nr = 0; e_nw = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!wr) begin
            e_lat = 2; e_nr = 1;
            w = ref_word(a);
            if (sz == 2'd0) begin
                e_rd = w >> 24;
                if (!uns && e_rd >= 128) e_rd = e_rd - 256;
            end else if (sz == 2'd1) begin
                e_rd = w >> 16;
                if (!uns && e_rd >= 32768) e_rd = e_rd - 65536;
            end else begin
                e_rd = w;
            end
        end else begin
            e_nw = 1;
            e_nr = (sz == 2'd2) ? 0 : 1;
            e_lat = (sz == 2'd2) ? 2 : 3;
            if (sz == 2'd0) begin
                ref_mem[a] = d[7:0];
            end else if (sz == 2'd1) begin
                ref_mem[a] = d[15:8]; ref_mem[a + 1] = d[7:0];
            end else begin
                ref_mem[a] = d[31:24]; ref_mem[a + 1] = d[23:16];
                ref_mem[a + 2] = d[15:8]; ref_mem[a + 3] = d[7:0];
            end
        end
    endtask

    // Issues one request, then reports what the DUT did; lat counts sampled cycles from the accepting edge.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int nr, output int nw, output int rbad);
        int waited;
        bit got;
        rd = 32'hDEAD_BEEF; er = 1'bx; lat = 99; nr = 0; nw = 0; rbad = 0; got = 0; waited = 0;
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_write = 1'($urandom);
        lat = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (mem_read && mem_address != PARK) nr++;
            if (mem_write) nw++;
            if (req_ready) rbad++;
            if (resp_valid) begin
                got = 1; rd = resp_rdata; er = resp_error;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready got %b expected 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_valid got %b expected 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_resp_rdata got %h expected 0", resp_rdata); end
        n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_resp_error got %b expected 0", resp_error); end
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_write got %b expected 0", mem_write); end
        n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_mem_read got %b expected 1", mem_read); end
        n_checks++; if (mem_address !== PARK) begin n_fail++; $display("[TB] FAIL reset_mem_address got %h expected %h", mem_address, PARK); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_wdata got %h expected 0", mem_wdata); end
    endtask

    task automatic test_loads();
        logic [31:0] rd, e_rd; logic er, e_err; int lat, nr, nw, rbad, e_lat, e_nr, e_nw;
        model_req(0, 2'd2, 0, 32'h10, 0, e_rd, e_err, e_lat, e_nr, e_nw);
        do_req(0, 2'd2, 0, 32'h10, 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== 32'h1122_3344) begin n_fail++; $display("[TB] FAIL lw_0x10_rdata got %h expected 11223344", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_0x10_error got %b expected 0", er); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL lw_0x10_latency got %0d expected 2", lat); end
        n_checks++; if (rbad !== 0) begin n_fail++; $display("[TB] FAIL lw_0x10_ready_busy got %0d expected 0", rbad); end
        model_req(0, 2'd0, 0, 32'h13, 0, e_rd, e_err, e_lat, e_nr, e_nw);
        do_req(0, 2'd0, 0, 32'h13, 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== 32'h0000_0044) begin n_fail++; $display("[TB] FAIL lb_0x13_rdata got %h expected 00000044", rd); end
        // Highest legal address reads the last four bytes of memory.
        model_req(0, 2'd1, 0, 32'(DEPTH - 4), 0, e_rd, e_err, e_lat, e_nr, e_nw);
        do_req(0, 2'd1, 0, 32'(DEPTH - 4), 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== e_rd || er !== e_err) begin n_fail++; $display("[TB] FAIL lh_top_addr got %h/%b expected %h/%b", rd, er, e_rd, e_err); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, e_rd; logic er, e_err; int lat, nr, nw, rbad, e_lat, e_nr, e_nw;
        logic [1:0]  sz [6] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd2};
        logic        wr [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [6] = '{32'h11, 32'h12, 32'd253, 32'h10, 32'd253, 32'd256};
        for (int i = 0; i < 6; i++) begin
            do_req(0, 2'd2, 0, 32'h10, 0, rd, er, lat, nr, nw, rbad);
            model_req(wr[i], sz[i], 0, ad[i], 32'h5A5A_5A5A, e_rd, e_err, e_lat, e_nr, e_nw);
            do_req(wr[i], sz[i], 0, ad[i], 32'h5A5A_5A5A, rd, er, lat, nr, nw, rbad);
            n_checks++; if (er !== 1'b1) begin n_fail++; $display("[TB] FAIL err%0d_flag got %b expected 1", i, er); end
            n_checks++; if (rd !== 32'h0) begin n_fail++; $display("[TB] FAIL err%0d_rdata got %h expected 0", i, rd); end
            n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL err%0d_latency got %0d expected 1", i, lat); end
            n_checks++; if (nw !== 0 || nr !== 0) begin n_fail++; $display("[TB] FAIL err%0d_mem_cycles got r%0d/w%0d expected r0/w0", i, nr, nw); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2; int cyc, first_at, second_at, acc2, rbad;
        r1 = 0; r2 = 0; cyc = 0; first_at = 0; second_at = 0; acc2 = 0; rbad = 0;
        @(negedge clk);
        req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_size = 2'd0; req_unsigned = 1; req_addr = 32'h13;
        while (second_at == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (resp_valid && first_at == 0) begin
                first_at = cyc; r1 = resp_rdata;
            end else if (resp_valid && acc2 != 0) begin
                second_at = cyc; r2 = resp_rdata;
            end
            if (req_ready && acc2 == 0) begin
                if (first_at == 0) rbad++;
                acc2 = cyc;
                @(posedge clk);
                #1;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_checks++; if (first_at !== 2 || r1 !== 32'h1122_3344) begin n_fail++; $display("[TB] FAIL b2b_first got %h at %0d expected 11223344 at 2", r1, first_at); end
        n_checks++; if (rbad !== 0 || acc2 <= first_at) begin n_fail++; $display("[TB] FAIL b2b_held_accept got ready-cycle %0d expected after %0d", acc2, first_at); end
        n_checks++; if (second_at !== acc2 + 2 || r2 !== 32'h44) begin n_fail++; $display("[TB] FAIL b2b_second got %h at %0d expected 00000044 at %0d", r2, second_at, acc2 + 2); end
    endtask

    task automatic test_store_byte_ext();
        logic [31:0] rd, e_rd; logic er, e_err; int lat, nr, nw, rbad, e_lat, e_nr, e_nw;
        model_req(1, 2'd0, 0, 32'h10, 32'h0000_00F0, e_rd, e_err, e_lat, e_nr, e_nw);
        do_req(1, 2'd0, 0, 32'h10, 32'h0000_00F0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_f0_resp got %h/%b expected 0/0", rd, er); end
        do_req(0, 2'd0, 0, 32'h10, 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== 32'hFFFF_FFF0) begin n_fail++; $display("[TB] FAIL lb_signed_f0 got %h expected fffffff0", rd); end
        do_req(0, 2'd0, 1, 32'h10, 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== 32'h0000_00F0) begin n_fail++; $display("[TB] FAIL lbu_f0 got %h expected 000000f0", rd); end
        do_req(0, 2'd1, 0, 32'h12, 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== 32'h0000_3344) begin n_fail++; $display("[TB] FAIL lh_0x12 got %h expected 00003344", rd); end
    endtask

    task automatic test_store_merge();
        logic [31:0] rd, e_rd; logic er, e_err; int lat, nr, nw, rbad, e_lat, e_nr, e_nw;
        model_req(1, 2'd2, 0, 32'h10, 32'h1122_3344, e_rd, e_err, e_lat, e_nr, e_nw);
        do_req(1, 2'd2, 0, 32'h10, 32'h1122_3344, rd, er, lat, nr, nw, rbad);
        n_checks++; if (lat !== 2 || nr !== 0 || nw !== 1) begin n_fail++; $display("[TB] FAIL sw_cycles got lat%0d r%0d w%0d expected lat2 r0 w1", lat, nr, nw); end
        model_req(1, 2'd0, 0, 32'h11, 32'h0000_00AB, e_rd, e_err, e_lat, e_nr, e_nw);
        do_req(1, 2'd0, 0, 32'h11, 32'h0000_00AB, rd, er, lat, nr, nw, rbad);
        n_checks++; if (lat !== 3 || nr !== 1 || nw !== 1) begin n_fail++; $display("[TB] FAIL sb_ab_cycles got lat%0d r%0d w%0d expected lat3 r1 w1", lat, nr, nw); end
        do_req(0, 2'd2, 0, 32'h10, 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== 32'h11AB_3344) begin n_fail++; $display("[TB] FAIL sb_ab_readback got %h expected 11ab3344", rd); end
        model_req(1, 2'd2, 0, 32'h10, 32'h1122_3344, e_rd, e_err, e_lat, e_nr, e_nw);
        do_req(1, 2'd2, 0, 32'h10, 32'h1122_3344, rd, er, lat, nr, nw, rbad);
        model_req(1, 2'd1, 0, 32'h12, 32'h0000_BEEF, e_rd, e_err, e_lat, e_nr, e_nw);
        do_req(1, 2'd1, 0, 32'h12, 32'h0000_BEEF, rd, er, lat, nr, nw, rbad);
        n_checks++; if (lat !== 3 || nr !== 1 || nw !== 1) begin n_fail++; $display("[TB] FAIL sh_beef_cycles got lat%0d r%0d w%0d expected lat3 r1 w1", lat, nr, nw); end
        do_req(0, 2'd2, 0, 32'h10, 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== 32'h1122_BEEF) begin n_fail++; $display("[TB] FAIL sh_beef_readback got %h expected 1122beef", rd); end
    endtask

    task automatic test_reset_during_write();
        logic [31:0] rd, expw; logic er; int lat, nr, nw, rbad;
        expw = ref_word(32'h20);
        @(negedge clk);
        req_write = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 32'h20; req_wdata = 32'h0000_00CD; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_wr_in_write got %b expected 1", mem_write); end
        rst_n = 1'b0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_req(0, 2'd2, 0, 32'h20, 0, rd, er, lat, nr, nw, rbad);
        n_checks++; if (rd !== expw || er !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_abandoned_write got %h expected %h", rd, expw); end
    endtask

    task automatic test_random();
        logic [31:0] rd, e_rd, a, d; logic er, e_err, wr, uns; logic [1:0] sz;
        int lat, nr, nw, rbad, e_lat, e_nr, e_nw, bad_bytes;
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom); uns = 1'($urandom); d = $urandom;
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, DEPTH + 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'd0) a = a & ((sz == 2'd1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
            model_req(wr, sz, uns, a, d, e_rd, e_err, e_lat, e_nr, e_nw);
            do_req(wr, sz, uns, a, d, rd, er, lat, nr, nw, rbad);
            n_checks++;
            if (rd !== e_rd || er !== e_err || lat !== e_lat || nr !== e_nr || nw !== e_nw || rbad !== 0) begin
                n_fail++;
                $display("[TB] FAIL rand%0d w%b sz%0d a=%h got rd=%h err=%b lat%0d r%0d w%0d rdy%0d expected rd=%h err=%b lat%0d r%0d w%0d rdy0",
                         i, wr, sz, a, rd, er, lat, nr, nw, rbad, e_rd, e_err, e_lat, e_nr, e_nw);
            end
        end
        @(negedge clk);
        bad_bytes = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
        n_checks++; if (bad_bytes !== 0) begin n_fail++; $display("[TB] FAIL final_memory got %0d differing bytes expected 0", bad_bytes); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'(i * 37 + 5);
            ref_mem[i] = 8'(i * 37 + 5);
        end
        mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
        ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;
        mem_rdata = 32'h0;
        rst_n = 1'b0; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] running directed scenarios");
        test_loads();
        test_errors();
        test_back_to_back();
        test_store_byte_ext();
        test_store_merge();
        test_reset_during_write();
        $display("[TB] running randomized scenarios");
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
